// File: rtl/ray_slab_hit_reduce_pkg.sv
// FloPoCo (WE=11, WF=20) word layout, exception codes and ordering helpers
// shared by the slab hit reducer and its comparator.
package ray_slab_hit_reduce_pkg;

    localparam int WE = 11;
    localparam int WF = 20;
    localparam int W  = WE + WF + 3;

    localparam int EXC_HI   = W - 1;
    localparam int EXC_LO   = W - 2;
    localparam int SIGN_BIT = W - 3;
    localparam int EXP_HI   = W - 4;
    localparam int EXP_LO   = WF;

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    localparam logic [W-1:0] FP_POS_ZERO = '0;

    // Coarse ordering class; only normals need a magnitude tie-break.
    localparam logic [2:0] CLS_NEG_INF  = 3'd0;
    localparam logic [2:0] CLS_NEG_NORM = 3'd1;
    localparam logic [2:0] CLS_ZERO     = 3'd2;
    localparam logic [2:0] CLS_POS_NORM = 3'd3;
    localparam logic [2:0] CLS_POS_INF  = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic is_nan(input logic [W-1:0] x);
        return x[EXC_HI:EXC_LO] == EXC_NAN;
    endfunction

    function automatic logic [W-4:0] fp_mag(input logic [W-1:0] x);
        return {x[EXP_HI:EXP_LO], x[EXP_LO-1:0]};
    endfunction

    function automatic logic [2:0] fp_class(input logic [W-1:0] x);
        logic [2:0] c;
        case (x[EXC_HI:EXC_LO])
            EXC_ZERO: c = CLS_ZERO;
            EXC_NORM: c = x[SIGN_BIT] ? CLS_NEG_NORM : CLS_POS_NORM;
            EXC_INF:  c = x[SIGN_BIT] ? CLS_NEG_INF : CLS_POS_INF;
            default:  c = CLS_ZERO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ray_slab_hit_reduce_fp_cmp.sv
// Combinational FloPoCo compare: a_ge_b in the total order (zero sign ignored);
// any NaN operand raises unordered and forces a_ge_b low.
module fp_cmp_flopoco
    import ray_slab_hit_reduce_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_ge_b,
    output logic         unordered
);

    logic [2:0] cls_a;
    logic [2:0] cls_b;

    always_comb begin
        cls_a     = fp_class(a);
        cls_b     = fp_class(b);
        unordered = is_nan(a) || is_nan(b);
        a_ge_b    = 1'b0;
        if (!unordered) begin
            if (cls_a != cls_b)
                a_ge_b = cls_a > cls_b;
            else if (cls_a == CLS_NEG_NORM)
                a_ge_b = fp_mag(a) <= fp_mag(b);
            else if (cls_a == CLS_POS_NORM)
                a_ge_b = fp_mag(a) >= fp_mag(b);
            else
                a_ge_b = 1'b1;
        end
    end

endmodule

// File: rtl/ray_slab_hit_reduce.sv
// Reduces per-axis {tnear,tfar} slabs to one hit/miss verdict per ray; verdict valid
// 2 cycles after the final beat's accept cycle; in_ready stays low until the verdict is taken.
module ray_slab_hit_reduce
    import ray_slab_hit_reduce_pkg::*;
#(
    parameter int NUM_AXES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_tnear,
    input  logic [W-1:0] in_tfar,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_hit,
    output logic         out_nan,
    output logic [W-1:0] out_tnear,
    output logic [W-1:0] out_tfar
);

    localparam int            CW        = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_AXES - 1);

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [W-1:0]  acc_near;
    logic [W-1:0]  acc_far;
    logic          acc_nan;

    logic          accept;
    logic          final_beat;
    logic          in_nan;
    logic          near_ge, near_uo, far_ge, far_uo;
    logic          res_le, res_le_uo, res_pos, res_pos_uo;
    logic [W-1:0]  next_near;
    logic [W-1:0]  next_far;

    assign in_ready   = !rst && (state == IDLE || state == ACC);
    assign accept     = in_valid && in_ready;
    assign final_beat = in_last || (beat_cnt == LAST_BEAT);
    assign in_nan     = is_nan(in_tnear) || is_nan(in_tfar);

    fp_cmp_flopoco u_max (.a(acc_near), .b(in_tnear),    .a_ge_b(near_ge), .unordered(near_uo));
    fp_cmp_flopoco u_min (.a(in_tfar),  .b(acc_far),     .a_ge_b(far_ge),  .unordered(far_uo));
    fp_cmp_flopoco u_le  (.a(acc_far),  .b(acc_near),    .a_ge_b(res_le),  .unordered(res_le_uo));
    fp_cmp_flopoco u_pos (.a(acc_far),  .b(FP_POS_ZERO), .a_ge_b(res_pos), .unordered(res_pos_uo));

    // Ties keep the accumulator; a NaN operand yields the other operand.
    assign next_near = near_uo ? (is_nan(in_tnear) ? acc_near : in_tnear)
                               : (near_ge ? acc_near : in_tnear);
    assign next_far  = far_uo  ? (is_nan(in_tfar) ? acc_far : in_tfar)
                               : (far_ge ? acc_far : in_tfar);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            acc_near  <= '0;
            acc_far   <= '0;
            acc_nan   <= 1'b0;
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_nan   <= 1'b0;
            out_tnear <= '0;
            out_tfar  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    acc_near <= in_tnear;
                    acc_far  <= in_tfar;
                    acc_nan  <= in_nan;
                    beat_cnt <= beat_cnt + CW'(1);
                    state    <= final_beat ? RESOLVE : ACC;
                end
                ACC: if (accept) begin
                    acc_near <= next_near;
                    acc_far  <= next_far;
                    acc_nan  <= acc_nan | in_nan;
                    beat_cnt <= beat_cnt + CW'(1);
                    if (final_beat)
                        state <= RESOLVE;
                end
                RESOLVE: begin
                    out_hit   <= !acc_nan && !res_le_uo && res_le && !res_pos_uo && res_pos;
                    out_nan   <= acc_nan;
                    out_tnear <= acc_near;
                    out_tfar  <= acc_far;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_slab_hit_reduce.sv
// Directed vectors for ray_slab_hit_reduce with hand-computed verdicts.
`timescale 1ns/1ps
module tb_ray_slab_hit_reduce;

    localparam int W = 34;
    localparam logic [W-1:0] F_1P0  = 34'h1_3FF00000;
    localparam logic [W-1:0] F_2P0  = 34'h1_40000000;
    localparam logic [W-1:0] F_3P0  = 34'h1_40080000;
    localparam logic [W-1:0] F_0P5  = 34'h1_3FE00000;
    localparam logic [W-1:0] F_M1P0 = 34'h1_BFF00000;
    localparam logic [W-1:0] F_M0P5 = 34'h1_BFE00000;
    localparam logic [W-1:0] F_PZ   = 34'h0_00000000;
    localparam logic [W-1:0] F_NZ   = 34'h0_80000000;
    localparam logic [W-1:0] F_PINF = 34'h2_00000000;
    localparam logic [W-1:0] F_NAN  = 34'h3_00000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_tnear;
    logic [W-1:0] in_tfar;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic         out_hit;
    logic         out_nan;
    logic [W-1:0] out_tnear;
    logic [W-1:0] out_tfar;

    int checks = 0;
    int errors = 0;

    ray_slab_hit_reduce #(.NUM_AXES(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_tnear(in_tnear), .in_tfar(in_tfar), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_nan(out_nan),
        .out_tnear(out_tnear), .out_tfar(out_tfar)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [W-1:0] tn, input logic [W-1:0] tf, input logic last);
        int n;
        in_valid = 1'b1;
        in_tnear = tn;
        in_tfar  = tf;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready for beat", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered right after the final beat: RESOLVE cycle, then DONE with the verdict.
    task automatic verdict(input string tag, input logic hit, input logic nan,
                           input logic [W-1:0] tn, input logic [W-1:0] tf);
        chk({tag, " out_valid low in resolve"}, out_valid, 0);
        chk({tag, " in_ready low in resolve"}, in_ready, 0);
        @(negedge clk);
        chk({tag, " out_valid"}, out_valid, 1);
        chk({tag, " out_hit"}, out_hit, hit);
        chk({tag, " out_nan"}, out_nan, nan);
        chk({tag, " out_tnear"}, out_tnear, tn);
        chk({tag, " out_tfar"}, out_tfar, tf);
    endtask

    task automatic release_verdict(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid after handshake"}, out_valid, 0);
        chk({tag, " in_ready after handshake"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_tnear  = '0;
        in_tfar   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_hit", out_hit, 0);
        chk("reset out_nan", out_nan, 0);
        chk("reset out_tnear", out_tnear, 0);
        chk("reset out_tfar", out_tfar, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle in_ready", in_ready, 1);

        // T1: near max 2.0, far min 2.0 -> touching slabs still hit
        send(F_1P0, F_3P0, 0);
        send(F_0P5, F_2P0, 0);
        send(F_2P0, F_3P0, 1);
        verdict("T1", 1, 0, F_2P0, F_2P0);

        // T5: verdict held under backpressure, stray in_valid ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_tnear = F_M1P0;
            in_tfar  = F_M0P5;
            in_last  = 1'b1;
            @(negedge clk);
            chk("T5 out_valid held", out_valid, 1);
            chk("T5 in_ready low", in_ready, 0);
            chk("T5 out_tnear stable", out_tnear, F_2P0);
            chk("T5 out_hit stable", out_hit, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_verdict("T5");
        chk("T5 out_tnear held after handshake", out_tnear, F_2P0);

        // T2: in_last ends the ray after 2 beats; 2.0 > 1.0 -> miss
        send(F_2P0, F_3P0, 0);
        send(F_0P5, F_1P0, 1);
        verdict("T2", 0, 0, F_2P0, F_1P0);
        release_verdict("T2");

        // T3a: box entirely behind origin
        send(F_M1P0, F_M0P5, 1);
        verdict("T3a", 0, 0, F_M1P0, F_M0P5);
        release_verdict("T3a");

        // T3b: exit exactly at +0 counts as hit
        send(F_M1P0, F_PZ, 1);
        verdict("T3b", 1, 0, F_M1P0, F_PZ);
        release_verdict("T3b");

        // T3c: third beat is forced final without in_last
        send(F_1P0, F_PINF, 0);
        send(F_1P0, F_PINF, 0);
        send(F_1P0, F_PINF, 0);
        verdict("T3c", 1, 0, F_1P0, F_PINF);
        release_verdict("T3c");

        // T4: NaN in the middle beat poisons the verdict but not the accumulators
        send(F_0P5, F_3P0, 0);
        send(F_NAN, F_2P0, 0);
        send(F_1P0, F_3P0, 1);
        verdict("T4", 0, 1, F_1P0, F_2P0);
        release_verdict("T4");

        // T7: -0 and +0 are equal, so tnear=+0, tfar=-0 hits
        send(F_PZ, F_NZ, 1);
        verdict("T7", 1, 0, F_PZ, F_NZ);
        release_verdict("T7");

        // T6: reset mid-ray clears outputs at once; next ray starts clean
        send(F_1P0, F_3P0, 0);
        send(F_0P5, F_2P0, 0);
        send(F_NAN, F_NAN, 0);
        verdict("T6 pre", 0, 1, F_1P0, F_2P0);
        release_verdict("T6 pre");
        send(F_1P0, F_3P0, 0);
        send(F_0P5, F_2P0, 0);
        rst = 1'b1;
        #1;
        chk("T6 rst out_valid", out_valid, 0);
        chk("T6 rst out_nan", out_nan, 0);
        chk("T6 rst out_hit", out_hit, 0);
        chk("T6 rst out_tnear", out_tnear, 0);
        chk("T6 rst out_tfar", out_tfar, 0);
        chk("T6 rst in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(F_0P5, F_1P0, 1);
        verdict("T6", 1, 0, F_0P5, F_1P0);
        release_verdict("T6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
